// File: rtl/memory_access_unit.sv
// Memory-stage load/store controller: decodes M-stage control, runs one handshaked bus
// transaction per memory instruction, and returns aligned, extended load data.
module memory_access_unit #(
    parameter int unsigned WIDTH_32       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                MemtoReg_M,
    input  logic                MemWrite_M,
    input  logic [3:0]          ByteControl_M,
    input  logic                LoadSigned_M,
    input  logic [WIDTH_32-1:0] ALU_result_M,
    input  logic [WIDTH_32-1:0] WriteData_M,
    output logic                Stall_M,
    output logic [WIDTH_32-1:0] ReadData_M,
    output logic                mem_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [WIDTH_32-1:0] mem_addr,
    output logic [3:0]          mem_be,
    output logic [WIDTH_32-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [WIDTH_32-1:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [WIDTH_32-1:0] addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [WIDTH_32-1:0] wdata_q, wdata_d;
    logic [WIDTH_32-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                signed_q, signed_d;

    logic                request;
    logic                legal_mask;
    logic                err_request;
    logic [WIDTH_32-1:0] store_data;
    logic [WIDTH_32-1:0] load_data;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;

    assign request     = MemtoReg_M | MemWrite_M;
    assign err_request = ~legal_mask | (MemtoReg_M & MemWrite_M);

    always_comb begin
        legal_mask = 1'b0;
        store_data = WriteData_M;
        case (ByteControl_M)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                legal_mask = 1'b1;
                store_data = {4{WriteData_M[7:0]}};
            end
            4'b0011, 4'b1100: begin
                legal_mask = 1'b1;
                store_data = {2{WriteData_M[15:0]}};
            end
            4'b1111: legal_mask = 1'b1;
            default: legal_mask = 1'b0;
        endcase
    end

    // Extraction keys off the registered mask/sign so it is independent of the held pipeline.
    always_comb begin
        lane_b    = 8'h00;
        lane_h    = 16'h0000;
        load_data = mem_rdata;
        case (be_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                case (be_q)
                    4'b0001: lane_b = mem_rdata[7:0];
                    4'b0010: lane_b = mem_rdata[15:8];
                    4'b0100: lane_b = mem_rdata[23:16];
                    default: lane_b = mem_rdata[31:24];
                endcase
                load_data = {{(WIDTH_32 - 8){signed_q & lane_b[7]}}, lane_b};
            end
            4'b0011, 4'b1100: begin
                lane_h    = (be_q == 4'b0011) ? mem_rdata[15:0] : mem_rdata[31:16];
                load_data = {{(WIDTH_32 - 16){signed_q & lane_h[15]}}, lane_h};
            end
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        signed_d = signed_q;
        unique case (state_q)
            StIdle: begin
                if (request) begin
                    rdata_d = '0;
                    if (err_request) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = StAccess;
                        req_d    = 1'b1;
                        we_d     = MemWrite_M;
                        addr_d   = {ALU_result_M[WIDTH_32-1:2], 2'b00};
                        be_d     = ByteControl_M;
                        wdata_d  = store_data;
                        signed_d = LoadSigned_M;
                        cnt_d    = '0;
                    end
                end
            end
            StAccess: begin
                if (mem_ack) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    rdata_d = we_q ? '0 : load_data;
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            signed_q <= signed_d;
        end
    end

    // Gated by rst_n so the hold is released immediately while reset is asserted.
    assign Stall_M    = rst_n & (((state_q == StIdle) & request) | (state_q == StAccess));
    assign ReadData_M = rdata_q;
    assign mem_err    = err_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage load/store controller between the EX/MEM pipeline register outputs and a handshaked data-memory bus. It decodes the M-stage control (MemtoReg_M, MemWrite_M, ByteControl_M), issues one word-aligned bus transaction per memory instruction with lane-aligned store data, and returns aligned, extended load data. While a transaction is in flight it raises Stall_M so the hazard logic deasserts EN on the upstream pipeline registers.

## Interface
- WIDTH_32, 32, data/address width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without mem_ack before abort (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- MemtoReg_M  in  1  load request
- MemWrite_M  in  1  store request
- ByteControl_M  in  4  byte-lane mask within addressed word
- LoadSigned_M  in  1  1 = sign-extend loads, 0 = zero-extend
- ALU_result_M  in  WIDTH_32  byte address
- WriteData_M  in  WIDTH_32  store data, right-justified
- Stall_M  out  1  hold upstream pipeline registers
- ReadData_M  out  WIDTH_32  aligned/extended load result, valid in DONE
- mem_err  out  1  access completed with error, high only in DONE
- mem_req  out  1  bus request, held until ack or timeout
- mem_we  out  1  1 = write
- mem_addr  out  WIDTH_32  {ALU_result_M[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  WIDTH_32  lane-replicated store data
- mem_ack  in  1  bus completion, one cycle
- mem_rdata  in  WIDTH_32  read data, valid with mem_ack

## Operation
- Request = MemtoReg_M | MemWrite_M. Legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Illegal mask, or both MemtoReg_M and MemWrite_M high, = error request.
- States: IDLE, ACCESS, DONE.
- IDLE: legal request -> ACCESS; register mem_req=1, mem_we=MemWrite_M, mem_addr, mem_be=ByteControl_M, mem_wdata; clear wait counter. Error request -> DONE with mem_err=1, no bus activity. No request -> stay.
- ACCESS: outputs held stable. mem_ack -> DONE, mem_req=0; loads capture extracted data into ReadData_M, stores leave ReadData_M=0. No ack and counter = TIMEOUT_CYCLES-1 -> DONE, mem_req=0, mem_err=1, ReadData_M=0. Otherwise counter+1.
- DONE: unconditional -> IDLE; mem_err cleared on exit.
- Stall_M combinational = (IDLE & request) | ACCESS. Low in DONE, so the pipeline advances at the DONE edge and the next instruction is evaluated in the following IDLE cycle.
- Store data: byte mask -> {4{WriteData_M[7:0]}}; half -> {2{WriteData_M[15:0]}}; word -> WriteData_M.
- Load data: byte lane k -> mem_rdata[8k+7:8k]; 0011 -> [15:0]; 1100 -> [31:16]; 1111 -> full word. Byte/half extended per LoadSigned_M.
- mem_ack outside ACCESS is ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0, mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadData_M, mem_err all 0. Stall_M 0 while rst_n low.
- Reset mid-ACCESS: mem_req drops in the same cycle; a later ack is ignored.
- Minimum memory instruction: 3 cycles (IDLE with stall, ACCESS with ack, DONE). Each extra wait cycle adds one.
- mem_req rises on the edge after the IDLE decision and falls on the edge that samples mem_ack.
- Timeout: exactly TIMEOUT_CYCLES ACCESS cycles, then DONE.
- Error request: 2 cycles (IDLE with stall, DONE with mem_err=1).
- Back-to-back memory instructions: no idle bubble beyond the mandatory IDLE cycle.
- Non-memory instruction: Stall_M=0, no state change.

## Test plan
- Store word: ALU_result_M=0x1004, WriteData_M=0xDEADBEEF, mask 1111, ack 2 cycles after mem_req -> mem_addr=0x1004, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1, Stall_M high 4 cycles, mem_err=0.
- Load byte signed: mask 0100, LoadSigned_M=1, mem_rdata=0x12F03456, immediate ack -> ReadData_M=0xFFFFFFF0 in DONE; same with LoadSigned_M=0 -> 0x000000F0.
- Store half upper: mask 1100, WriteData_M=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD; load half 1100 of mem_rdata=0x8001FFFF, unsigned -> 0x00008001.
- Timeout: load, never ack, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then DONE with mem_err=1, ReadData_M=0; next load with ack completes normally.
- Error request: mask 0110, or MemtoReg_M=MemWrite_M=1 -> mem_req never rises, mem_err=1 for one cycle, Stall_M high 1 cycle.
- Async reset during ACCESS, plus a stray ack while in IDLE -> all outputs 0 immediately, stray ack causes no state change, next request starts cleanly.
